bus_transfer_ctrl: RTL
======================

# bus_transfer_ctrl

Sequencer for the driving and receiving ends of the shared 32-bit datapath bus. It accepts one register-transfer request at a time and emits the one-hot source output-enables (R0out…Cout) that steer the bus mux. It then pulses the one-hot destination load-enables (R0in…OutPortin) to capture the bus value. It also resolves IR-relative register fields (Ra/Rb/Rc) and produces the sign-extended C constant that the bus selects when Cout is high.

## Interface
- DRIVE_CYCLES, 1: number of cycles the source drives the bus before the load strobe; legal range 1–15.

- clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-high reset
- req_valid  in  1  transfer request present
- req_ready  out  1  high only in IDLE; a request is accepted on a cycle where req_valid && req_ready
- req_src  in  5  source code:
  - 0–15: R0–R15
  - 16: MDR; 17: HI; 18: LO; 19: Zhigh; 20: Zlow; 21: PC; 22: InPort; 23: C
  - 24/25/26: register named by IR Ra/Rb/Rc
  - 27–31: illegal
- req_dst  in  5  destination code:
  - 0–15: R0–R15
  - 16: MDR; 17: HI; 18: LO; 19: PC; 20: IR; 21: MAR; 22: Y; 23: OutPort
  - 24/25/26: IR Ra/Rb/Rc
  - 31: none
  - 27–30: illegal
- ir  in  32  instruction register; Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15], C=ir[18:0]
- src_oe  out  24  one-hot output enables; bit n = source code n
- dst_le  out  24  one-hot load enables; bit n = destination code n
- c_sign_extended  out  32  {{13{C[18]}}, C} captured at accept
- done  out  1  one-cycle pulse marking completion
- err  out  1  one-cycle pulse on a rejected request

## Operation
- States:
  - IDLE: req_ready=1.
  - DRIVE: src_oe is one-hot on the resolved source.
  - LATCH: src_oe is held; dst_le is one-hot on the resolved destination, or all zero for dst 31; done=1.
- On accept in IDLE:
  - Codes 24–26 are resolved to 0–15 using ir sampled in the accept cycle.
  - The resolved src index, resolved dst index and c_sign_extended are registered.
  - The DRIVE counter is loaded with DRIVE_CYCLES.
- Illegal src (27–31) or illegal dst (27–30):
  - The request is still consumed (ready high in the accept cycle).
  - err pulses the next cycle.
  - State stays IDLE; no src_oe or dst_le activity.
- Transitions:
  - IDLE → DRIVE on a legal accept.
  - DRIVE → LATCH when the counter reaches 1; otherwise decrement and stay.
  - LATCH → IDLE unconditionally.
- Invariants:
  - src_oe and dst_le are always all-zero or exactly one-hot; never more than one bit each.
  - dst_le never asserts without src_oe asserted in the same cycle.
- Same register as src and dst (e.g. R3→R3) is legal; it is sequenced normally.
- ir changes after accept have no effect on the in-flight transfer or on c_sign_extended.
- c_sign_extended holds its last value until the next legal accept.
- All outputs are registered; none depend combinationally on req_* or ir, except req_ready, which is decoded from state.

## Timing
- Reset (clear high, at any time, including mid-transfer):
  - Immediately src_oe=0, dst_le=0, c_sign_extended=0, done=0, err=0.
  - State returns to IDLE; req_ready=1 once clear is released.
  - The aborted transfer is discarded and done never fires for it.
- Legal request accepted at edge T:
  - src_oe high for cycles T+1 … T+DRIVE_CYCLES+1.
  - dst_le and done high for cycle T+DRIVE_CYCLES+1 only.
  - req_ready is high again in cycle T+DRIVE_CYCLES+2.
  - Total occupancy is DRIVE_CYCLES+1 cycles; throughput is one transfer per DRIVE_CYCLES+2 cycles.
- Illegal request accepted at T: err high in cycle T+1; req_ready stays high, so a new request is accepted at T+1.
- req_valid held high across a completion: the next request is accepted on the first IDLE cycle, with no bubble beyond the IDLE cycle.

## Test plan
- Reset mid-DRIVE (DRIVE_CYCLES=3, R5→R2, clear asserted in the second DRIVE cycle):
  - Required: src_oe and dst_le are 0 immediately; no done pulse; req_ready=1 after release.
- Basic transfer, DRIVE_CYCLES=1, src=21 (PC), dst=21 (MAR):
  - Required: src_oe=24'h200000 for 2 cycles.
  - Required: dst_le=24'h200000 and done=1 in the second cycle; ready returns the following cycle.
- IR-relative transfer, ir=32'h0118_0000 (Ra=2, Rb=3), src=25, dst=24:
  - Required: src_oe bit 3 and dst_le bit 2.
  - Required: changing ir after accept leaves both unchanged.
- C constant, ir[18:0]=19'h40005, src=23, dst=22 (Y):
  - Required: c_sign_extended=32'hFFFC0005.
  - Required: src_oe=24'h800000, dst_le=24'h400000.
- Illegal codes, src=28 then dst=29:
  - Required: one err pulse per request; src_oe and dst_le remain 0; ready never drops.
- Back-to-back with req_valid held, R1→HI then LO→R7, DRIVE_CYCLES=2:
  - Required: second accept in the IDLE cycle right after the first LATCH.
  - Required: strobes never overlap and each is one-hot.

Source files
------------

// File: rtl/bus_transfer_ctrl.sv
// Bus transfer sequencer: accepts one register transfer at a time, drives the one-hot
// source output-enable for DRIVE_CYCLES+1 cycles and pulses the destination load-enable.
module bus_transfer_ctrl #(
    parameter int unsigned DRIVE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_src,
    input  logic [4:0]  req_dst,
    input  logic [31:0] ir,
    output logic [23:0] src_oe,
    output logic [23:0] dst_le,
    output logic [31:0] c_sign_extended,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StDrive, StLatch} state_e;

    localparam logic [3:0] DriveLoad = 4'(DRIVE_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] src_oe_q, src_oe_d;
    logic [23:0] dst_le_q, dst_le_d;
    logic [23:0] dst_oh_q, dst_oh_d;
    logic [31:0] c_q, c_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [4:0]  src_res, dst_res;
    logic        legal;
    logic        unused_ir;

    assign unused_ir = ^ir[31:27];

    // IR-relative codes 24..26 map onto R0..R15 via the Ra/Rb/Rc fields.
    always_comb begin
        src_res = req_src;
        case (req_src)
            5'd24:   src_res = {1'b0, ir[26:23]};
            5'd25:   src_res = {1'b0, ir[22:19]};
            5'd26:   src_res = {1'b0, ir[18:15]};
            default: ;
        endcase
    end

    always_comb begin
        dst_res = req_dst;
        case (req_dst)
            5'd24:   dst_res = {1'b0, ir[26:23]};
            5'd25:   dst_res = {1'b0, ir[22:19]};
            5'd26:   dst_res = {1'b0, ir[18:15]};
            default: ;
        endcase
    end

    assign legal = (req_src <= 5'd26) && ((req_dst <= 5'd26) || (req_dst == 5'd31));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        src_oe_d = src_oe_q;
        dst_le_d = '0;
        dst_oh_d = dst_oh_q;
        c_d      = c_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (legal) begin
                        src_oe_d = 24'd1 << src_res;
                        dst_oh_d = (req_dst == 5'd31) ? 24'd0 : (24'd1 << dst_res);
                        c_d      = {{13{ir[18]}}, ir[18:0]};
                        cnt_d    = DriveLoad;
                        state_d  = StDrive;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StDrive: begin
                if (cnt_q <= 4'd1) begin
                    dst_le_d = dst_oh_q;
                    done_d   = 1'b1;
                    state_d  = StLatch;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StLatch: begin
                src_oe_d = '0;
                state_d  = StIdle;
            end
            default: begin
                src_oe_d = '0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            src_oe_q <= '0;
            dst_le_q <= '0;
            dst_oh_q <= '0;
            c_q      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            src_oe_q <= src_oe_d;
            dst_le_q <= dst_le_d;
            dst_oh_q <= dst_oh_d;
            c_q      <= c_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign req_ready       = (state_q == StIdle);
    assign src_oe          = src_oe_q;
    assign dst_le          = dst_le_q;
    assign c_sign_extended = c_q;
    assign done            = done_q;
    assign err             = err_q;

endmodule
